bresenham_line: RTL and testbench
=================================

Name: bresenham_line

Overview:
- Line-drawing stage directly downstream of the initiator.
- Consumes the two segment endpoints (point_out_a / point_out_b) when the initiator raises req_init_br.
- Emits one pixel per accepted handshake, with x, y and interpolated z, from endpoint a to endpoint b inclusive.
- Feeds the z-compare / z-buffer write stage through a valid/ready pixel stream.

Parameters:
- COORD_W, 8, width of each of x, y, z; point width is 3*COORD_W.
- ERR_W, COORD_W+3, signed width of the error accumulators.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active high
- req_br  in  1  segment request from initiator (req_init_br)
- ack_br  out  1  one-cycle acknowledge; endpoints latched
- point_a  in  24  start point {x[23:16], y[15:8], z[7:0]}
- point_b  in  24  end point, same packing
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  8  pixel x
- pix_y  out  8  pixel y
- pix_z  out  8  pixel z
- pix_eol  out  1  marks last pixel of the segment; qualified by pix_valid
- eoc_br  out  1  one-cycle pulse after the last pixel is accepted
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. rst forces state IDLE and all outputs to 0. Reset mid-line abandons the segment with no eoc_br.
- States and transitions:
  - IDLE -> SETUP when req_br is sampled high.
  - SETUP -> DIV after 1 cycle.
  - DIV -> RUN after exactly 8 cycles.
  - RUN -> DONE when the eol pixel is accepted.
  - DONE -> IDLE after 1 cycle.
- Request handling:
  - req_br sampled in IDLE at edge k latches point_a/point_b. ack_br is high for the cycle after edge k.
  - req_br outside IDLE is ignored, with no ack.
- SETUP:
  - dx=|xb-xa|, dy=|yb-ya|, dz=|zb-za|.
  - sx, sy, sz = +1 or -1; 0 difference gives +1.
  - L=max(dx,dy).
- DIV:
  - Restoring divide q=dz/L, r=dz%L, one quotient bit per cycle, MSB first, 8 cycles fixed.
  - If L==0, force q=0, r=0.
- Error initialisation:
  - ex=2dx-L, ey=2dy-L, ez=2r-L, all signed ERR_W.
  - Current point = point a.
- RUN output:
  - pix_valid high from cycle k+10; first pixel = point a.
  - While pix_valid && !pix_ready, all pix_* outputs are held stable.
- Step (on pix_valid && pix_ready, unless eol):
  - For axis x: if ex>=0 then x+=sx and ex-=2L; then ex+=2dx.
  - Axis y: same rule with ey, sy, dy.
  - z+=sz*q; if ez>=0 then z+=sz and ez-=2L; then ez+=2r.
- Pixel count and eol:
  - Exactly L+1 pixels are produced; the final pixel equals point b exactly.
  - pix_eol is high on pixel number L+1.
  - L==0 gives a single pixel {xa, ya, za} with eol; z of point b is ignored.
- Back-to-back: throughput is one pixel per cycle when pix_ready is held high. No overflow or wrap: all coordinates stay within the endpoint span.
- Completion:
  - eoc_br pulses in DONE, the cycle after eol is accepted; pix_valid is low in DONE.
  - A new req_br is accepted from the following IDLE cycle.

Decomposition:
- Package zb_pkg:
  - point_t packed struct {x, y, z} of COORD_W each.
  - br_state_t enum {IDLE, SETUP, DIV, RUN, DONE}.
  - COORD_W constant.
  - Field-extract helper functions.
- Sub-module seq_div8: 8-cycle restoring divider with start/done handshake, used for q and r. The rest of the logic stays in bresenham_line.

Test Plan:
- a=24'h013201, b=24'h324501, pix_ready=1 -> ack_br at k+1; first pixel (01,32,01) at k+10; 50 pixels; last (32,45,01) with eol; eoc_br one cycle later.
- a=(0,0,0), b=(3,0,6) -> pixels (0,0,0) (1,0,2) (2,0,4) (3,0,6); q=2, r=0.
- a=(0,0,0), b=(4,0,2) -> z sequence 0,1,1,2,2; x 0..4; 5 pixels.
- a=(5,5,10), b=(0,2,0), pix_ready low 3 cycles after pixel 2 -> outputs stable while stalled; pixels (5,5,10) (4,4,8) (3,4,6) (2,3,4) (1,3,2) (0,2,0).
- a=b=24'h102030 -> single pixel (10,20,30) with eol; eoc_br next cycle.
- req_br pulsed during RUN -> no ack_br, line unaffected. rst asserted mid-RUN -> all outputs 0 immediately, state IDLE, no eoc_br. A new req after reset is acked normally.

Source files
------------

// File: rtl/zb_pkg.sv
// Shared types and helpers for the z-buffer pixel pipeline.
// Points are packed {x, y, z}, with x in the most significant bits.
package zb_pkg;
  localparam int COORD_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point_t;

  typedef enum logic [2:0] {IDLE, SETUP, DIV, RUN, DONE} br_state_t;

  function automatic logic [COORD_W-1:0] pt_x(input point_t p);
    return p.x;
  endfunction

  function automatic logic [COORD_W-1:0] pt_y(input point_t p);
    return p.y;
  endfunction

  function automatic logic [COORD_W-1:0] pt_z(input point_t p);
    return p.z;
  endfunction

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction
endpackage

// File: rtl/seq_div8.sv
// Restoring divider: one quotient bit per cycle, MSB first.
// o_q/o_r are final in the cycle where o_done pulses.
module seq_div8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_r
);
  logic [W-1:0] r_rem, r_quo, r_dvs;
  logic [2:0]   r_cnt;
  logic         r_run, r_done;

  logic [W-1:0] w_rem_src, w_quo_src, w_dvs;
  logic [W:0]   w_sh, w_diff;
  logic         w_ge;

  // The start cycle already performs the first iteration, so 8 bits finish
  // within 8 edges of the start edge.
  assign w_rem_src = i_start ? '0 : r_rem;
  assign w_quo_src = i_start ? i_dividend : r_quo;
  assign w_dvs     = i_start ? i_divisor : r_dvs;
  assign w_sh      = {w_rem_src, w_quo_src[W-1]};
  assign w_ge      = (w_sh >= {1'b0, w_dvs});
  assign w_diff    = w_ge ? (w_sh - {1'b0, w_dvs}) : w_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_run) begin
        r_rem <= w_diff[W-1:0];
        r_quo <= {w_quo_src[W-2:0], w_ge};
        r_dvs <= w_dvs;
      end
      if (i_start) begin
        r_cnt <= 3'd7;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_q    = r_quo;
  assign o_r    = r_rem;
endmodule

// File: rtl/bresenham_line.sv
// Bresenham line stage: walks from point_a to point_b inclusive, one pixel
// per accepted handshake, with z interpolated via q = dz/L and remainder error.
module bresenham_line
  import zb_pkg::*;
#(
  parameter int COORD_W = zb_pkg::COORD_W,
  parameter int ERR_W   = COORD_W + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_br,
  output logic                 ack_br,
  input  logic [3*COORD_W-1:0] point_a,
  input  logic [3*COORD_W-1:0] point_b,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic [COORD_W-1:0]   pix_z,
  output logic                 pix_eol,
  output logic                 eoc_br,
  output logic                 busy,
  output br_state_t            dbg_state
);
  // Pixel stream: a pixel transfers on a rising edge where pix_valid and
  // pix_ready are both high; while valid && !ready every pix_* output holds.
  br_state_t               r_state;
  point_t                  r_a, r_b;
  logic [COORD_W-1:0]      r_x, r_y, r_z, r_dx, r_dy, r_l, r_q, r_r, r_cnt;
  logic                    r_sx, r_sy, r_sz;
  logic signed [ERR_W-1:0] r_ex, r_ey, r_ez;
  logic                    r_ack, r_valid, r_eol, r_eoc, r_busy;

  logic [COORD_W-1:0]      w_dx, w_dy, w_dz, w_l, w_div_q, w_div_r, w_q0, w_r0;
  logic                    w_div_done, w_hs, w_step_x, w_step_y, w_step_z;
  logic signed [ERR_W-1:0] w_dx2, w_dy2, w_r2, w_r2i, w_l1, w_l2;
  logic signed [ERR_W-1:0] w_ex_n, w_ey_n, w_ez_n;
  logic [COORD_W-1:0]      w_x_n, w_y_n, w_zq, w_z_n;

  assign w_dx = abs_diff(r_a.x, r_b.x);
  assign w_dy = abs_diff(r_a.y, r_b.y);
  assign w_dz = abs_diff(r_a.z, r_b.z);
  assign w_l  = (w_dx >= w_dy) ? w_dx : w_dy;

  seq_div8 #(.W(COORD_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_state == SETUP),
    .i_dividend (w_dz),
    .i_divisor  (w_l),
    .o_done     (w_div_done),
    .o_q        (w_div_q),
    .o_r        (w_div_r)
  );

  // A zero-length segment has no z slope; its single pixel is point a.
  assign w_q0 = (r_l == '0) ? '0 : w_div_q;
  assign w_r0 = (r_l == '0) ? '0 : w_div_r;

  assign w_dx2 = {{(ERR_W-COORD_W-1){1'b0}}, r_dx, 1'b0};
  assign w_dy2 = {{(ERR_W-COORD_W-1){1'b0}}, r_dy, 1'b0};
  assign w_r2  = {{(ERR_W-COORD_W-1){1'b0}}, r_r, 1'b0};
  assign w_r2i = {{(ERR_W-COORD_W-1){1'b0}}, w_r0, 1'b0};
  assign w_l1  = {{(ERR_W-COORD_W){1'b0}}, r_l};
  assign w_l2  = {{(ERR_W-COORD_W-1){1'b0}}, r_l, 1'b0};

  assign w_hs     = r_valid & pix_ready;
  assign w_step_x = ~r_ex[ERR_W-1];
  assign w_step_y = ~r_ey[ERR_W-1];
  assign w_step_z = ~r_ez[ERR_W-1];

  assign w_ex_n = r_ex - (w_step_x ? w_l2 : '0) + w_dx2;
  assign w_ey_n = r_ey - (w_step_y ? w_l2 : '0) + w_dy2;
  assign w_ez_n = r_ez - (w_step_z ? w_l2 : '0) + w_r2;

  assign w_x_n = w_step_x ? (r_sx ? r_x - 1'b1 : r_x + 1'b1) : r_x;
  assign w_y_n = w_step_y ? (r_sy ? r_y - 1'b1 : r_y + 1'b1) : r_y;
  assign w_zq  = r_sz ? r_z - r_q : r_z + r_q;
  assign w_z_n = w_step_z ? (r_sz ? w_zq - 1'b1 : w_zq + 1'b1) : w_zq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_l     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_sz    <= 1'b0;
      r_ex    <= '0;
      r_ey    <= '0;
      r_ez    <= '0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_eoc   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_eoc <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_br) begin
            r_a     <= point_t'(point_a);
            r_b     <= point_t'(point_b);
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_dx    <= w_dx;
          r_dy    <= w_dy;
          r_l     <= w_l;
          r_sx    <= (r_b.x < r_a.x);
          r_sy    <= (r_b.y < r_a.y);
          r_sz    <= (r_b.z < r_a.z);
          r_state <= DIV;
        end
        DIV: begin
          if (w_div_done) begin
            r_q     <= w_q0;
            r_r     <= w_r0;
            r_ex    <= w_dx2 - w_l1;
            r_ey    <= w_dy2 - w_l1;
            r_ez    <= w_r2i - w_l1;
            r_x     <= r_a.x;
            r_y     <= r_a.y;
            r_z     <= r_a.z;
            r_cnt   <= r_l;
            r_eol   <= (r_l == '0);
            r_valid <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_hs) begin
            if (r_eol) begin
              r_valid <= 1'b0;
              r_eol   <= 1'b0;
              r_eoc   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_x   <= w_x_n;
              r_y   <= w_y_n;
              r_z   <= w_z_n;
              r_ex  <= w_ex_n;
              r_ey  <= w_ey_n;
              r_ez  <= w_ez_n;
              r_cnt <= r_cnt - 1'b1;
              r_eol <= (r_cnt == 1);
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack_br    = r_ack;
  assign pix_valid = r_valid;
  assign pix_x     = r_x;
  assign pix_y     = r_y;
  assign pix_z     = r_z;
  assign pix_eol   = r_eol;
  assign eoc_br    = r_eoc;
  assign busy      = r_busy;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_bresenham_line.sv
// Bench for bresenham_line: directed segments, scoreboard of expected
// {x, y, z, eol} pixels popped by a monitor on every accepted handshake.
module tb_bresenham_line;
  import zb_pkg::*;

  localparam int W  = 8;
  localparam int PW = 3 * W + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_br = 1'b0;
  logic            ack_br;
  logic [3*W-1:0]  point_a = '0;
  logic [3*W-1:0]  point_b = '0;
  logic            pix_valid;
  logic            pix_ready = 1'b0;
  logic [W-1:0]    pix_x, pix_y, pix_z;
  logic            pix_eol, eoc_br, busy;
  br_state_t       dbg_state;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [PW-1:0]   exp_q[$];
  logic [PW-1:0]   exp_pix, prev_out;
  int              n_acc = 0;
  logic            eoc_seen = 1'b0;
  logic            prev_eol_hs = 1'b0;
  logic            prev_stall = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bresenham_line dut (
    .clk       (clk),
    .rst       (rst),
    .req_br    (req_br),
    .ack_br    (ack_br),
    .point_a   (point_a),
    .point_b   (point_b),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_z     (pix_z),
    .pix_eol   (pix_eol),
    .eoc_br    (eoc_br),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_eol_hs = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (eoc_br || prev_eol_hs) begin
        check("eoc_timing", 32'(eoc_br), 32'(prev_eol_hs));
        if (eoc_br) begin
          check("valid_low_in_done", 32'(pix_valid), 32'(0));
          eoc_seen = 1'b1;
        end
      end
      if (prev_stall) begin
        check("stall_valid", 32'(pix_valid), 32'(1));
        check("stall_hold", 32'({pix_x, pix_y, pix_z, pix_eol}), 32'(prev_out));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pixel: got %0h expected none", {pix_x, pix_y, pix_z, pix_eol});
        end else begin
          exp_pix = exp_q.pop_front();
          check("pixel", 32'({pix_x, pix_y, pix_z, pix_eol}), 32'(exp_pix));
        end
        n_acc++;
      end
      prev_eol_hs = pix_valid && pix_ready && pix_eol;
      prev_stall  = pix_valid && !pix_ready;
      prev_out    = {pix_x, pix_y, pix_z, pix_eol};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pix(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, input logic eol);
    exp_q.push_back({x, y, z, eol});
  endtask

  // Closed-form reference: offset on each axis at step i is
  // floor((2*i*d + L) / (2*L)), which is where the error-walk lands.
  task automatic push_line(input logic [3*W-1:0] a, input logic [3*W-1:0] b);
    int xa, ya, za, xb, yb, zb, dx, dy, dz, l, sx, sy, sz, x, y, z;
    xa = int'(a[23:16]); ya = int'(a[15:8]); za = int'(a[7:0]);
    xb = int'(b[23:16]); yb = int'(b[15:8]); zb = int'(b[7:0]);
    sx = (xb >= xa) ? 1 : -1; dx = (xb - xa) * sx;
    sy = (yb >= ya) ? 1 : -1; dy = (yb - ya) * sy;
    sz = (zb >= za) ? 1 : -1; dz = (zb - za) * sz;
    l  = (dx >= dy) ? dx : dy;
    if (l == 0) begin
      push_pix(W'(xa), W'(ya), W'(za), 1'b1);
    end else begin
      for (int i = 0; i <= l; i++) begin
        x = xa + sx * ((2 * i * dx + l) / (2 * l));
        y = ya + sy * ((2 * i * dy + l) / (2 * l));
        z = za + sz * ((2 * i * dz + l) / (2 * l));
        push_pix(W'(x), W'(y), W'(z), i == l);
      end
    end
  endtask

  task automatic send_req(input logic [3*W-1:0] a, input logic [3*W-1:0] b);
    @(posedge clk); #1;
    point_a = a;
    point_b = b;
    req_br  = 1'b1;
    @(posedge clk); #1;
    req_br = 1'b0;
    check("ack_br_k1", 32'(ack_br), 32'(1));
    check("busy_k1", 32'(busy), 32'(1));
    @(posedge clk); #1;
    check("ack_br_one_cycle", 32'(ack_br), 32'(0));
    repeat (7) @(posedge clk);
    #1;
    check("valid_low_before_k10", 32'(pix_valid), 32'(0));
    @(posedge clk); #1;
    check("valid_at_k10", 32'(pix_valid), 32'(1));
  endtask

  task automatic wait_line(input int budget);
    int c = 0;
    while (!eoc_seen && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("line_done", 32'(eoc_seen), 32'(1));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_state", 32'(dbg_state), 32'(IDLE));
    eoc_seen = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_acc(input int n, input int budget);
    int c = 0;
    while (n_acc < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("accept_count", 32'(n_acc >= n), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({ack_br, pix_valid, pix_x, pix_y, pix_z, pix_eol, eoc_br, busy}), 32'(0));
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // Long shallow line, ready held high
    pix_ready = 1'b1;
    push_line(24'h013201, 24'h324501);
    send_req(24'h013201, 24'h324501);
    wait_line(200);

    // z slope with zero remainder; request pulsed mid-RUN must be ignored
    push_pix(8'd0, 8'd0, 8'd0, 1'b0);
    push_pix(8'd1, 8'd0, 8'd2, 1'b0);
    push_pix(8'd2, 8'd0, 8'd4, 1'b0);
    push_pix(8'd3, 8'd0, 8'd6, 1'b1);
    send_req(24'h000000, 24'h030006);
    point_a = 24'h777777;
    point_b = 24'h111111;
    req_br  = 1'b1;
    @(posedge clk); #1;
    req_br = 1'b0;
    check("no_ack_in_run", 32'(ack_br), 32'(0));
    wait_line(40);

    // z slope below one per step
    push_pix(8'd0, 8'd0, 8'd0, 1'b0);
    push_pix(8'd1, 8'd0, 8'd1, 1'b0);
    push_pix(8'd2, 8'd0, 8'd1, 1'b0);
    push_pix(8'd3, 8'd0, 8'd2, 1'b0);
    push_pix(8'd4, 8'd0, 8'd2, 1'b1);
    send_req(24'h000000, 24'h040002);
    wait_line(40);

    // All-negative directions with a 3-cycle stall after pixel 2
    push_pix(8'd5, 8'd5, 8'd10, 1'b0);
    push_pix(8'd4, 8'd4, 8'd8, 1'b0);
    push_pix(8'd3, 8'd4, 8'd6, 1'b0);
    push_pix(8'd2, 8'd3, 8'd4, 1'b0);
    push_pix(8'd1, 8'd3, 8'd2, 1'b0);
    push_pix(8'd0, 8'd2, 8'd0, 1'b1);
    n_acc = 0;
    send_req(24'h05050A, 24'h000200);
    wait_acc(2, 20);
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pix_ready = 1'b1;
    wait_line(40);

    // Degenerate single-point segment
    push_pix(8'h10, 8'h20, 8'h30, 1'b1);
    send_req(24'h102030, 24'h102030);
    wait_line(20);

    // Reset in the middle of RUN abandons the segment
    pix_ready = 1'b0;
    send_req(24'h000000, 24'h040002);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", 32'({ack_br, pix_valid, pix_x, pix_y, pix_z, pix_eol, eoc_br, busy}), 32'(0));
    check("midrun_reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_eoc_after_reset", 32'({eoc_br, eoc_seen, pix_valid}), 32'(0));

    // Fresh request after reset is served normally
    push_line(24'h000000, 24'h030006);
    send_req(24'h000000, 24'h030006);
    wait_line(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
